// File: rtl/nn_pkg.sv
// Shared constants and FSM encoding for the argmax classifier stage.
package nn_pkg;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;
  localparam logic [DATA_W-1:0] NEG_MAX = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;
endpackage

// File: rtl/nn_argmax_if.sv
// Control handshake, shared output-RAM port and result bus of the argmax stage.
interface nn_argmax_if;
  import nn_pkg::*;

  logic              start;
  logic [IDX_W-1:0]  num_of_output;
  logic [31:0]       output_addr;
  logic              output_en;
  logic [3:0]        output_we;
  logic [DATA_W-1:0] output_dout;
  logic              busy;
  logic              done;
  logic              valid;
  logic              empty;
  logic [IDX_W-1:0]  class_idx;
  logic [DATA_W-1:0] class_val;

  // argmax block side
  modport slave (
    input  start, num_of_output, output_dout,
    output output_addr, output_en, output_we,
    output busy, done, valid, empty, class_idx, class_val
  );

  // core / RAM side
  modport master (
    output start, num_of_output, output_dout,
    input  output_addr, output_en, output_we,
    input  busy, done, valid, empty, class_idx, class_val
  );
endinterface

// File: rtl/nn_max_cmp.sv
// Registered signed running-max; strictly-greater update so ties keep the earlier index.
module nn_max_cmp
  import nn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_val,
  input  logic [IDX_W-1:0]  in_idx,
  output logic [DATA_W-1:0] max_val,
  output logic [IDX_W-1:0]  max_idx
);
  logic [DATA_W-1:0] max_val_q;
  logic [IDX_W-1:0]  max_idx_q;

  // clr presets the most negative value so any real word (or none) resolves correctly
  always_ff @(posedge clk) begin
    if (rst) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (clr) begin
      max_val_q <= NEG_MAX;
      max_idx_q <= '0;
    end else if (in_valid && ($signed(in_val) > $signed(max_val_q))) begin
      max_val_q <= in_val;
      max_idx_q <= in_idx;
    end
  end

  assign max_val = max_val_q;
  assign max_idx = max_idx_q;
endmodule

// File: rtl/nn_argmax.sv
// Scans N signed output-RAM words after a layer completes and reports index/value of the max.
module nn_argmax
  import nn_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          ADDR_STRIDE = 4,
  parameter int          RD_LAT      = 1    // 1..2
)(
  input  logic        nnclk,
  input  logic        nnreset,
  nn_argmax_if.slave  bus
);
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic              valid_q, valid_d;
  logic              empty_q, empty_d;
  logic              clr;
  logic              rd_en;

  // valid bit and neuron index travel alongside each read until its data returns
  logic [RD_LAT-1:0]            vld_pipe_q;
  logic [RD_LAT-1:0][IDX_W-1:0] idx_pipe_q;

  // next-state and per-state controls
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    addr_d  = addr_q;
    dcnt_d  = dcnt_q;
    valid_d = valid_q;
    empty_d = empty_q;
    clr     = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          valid_d = 1'b0;
          empty_d = 1'b0;
          if (bus.num_of_output == '0) begin
            // nothing to scan: result is the preset, flagged empty
            state_d = FIN;
            empty_d = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d = ISSUE;
            n_d     = bus.num_of_output;
            k_d     = '0;
            addr_d  = BASE_ADDR;
          end
        end
      end
      ISSUE: begin
        rd_en = 1'b1;
        if (k_q == n_q - 1'b1) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d    = k_q + 1'b1;
          addr_d = addr_q + 32'(ADDR_STRIDE);
        end
      end
      DRAIN: begin
        // address holds; wait until the last word has passed the comparator
        if (dcnt_q == 2'(RD_LAT - 1)) begin
          state_d = FIN;
          valid_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge nnclk) begin
    if (nnreset) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      dcnt_q  <= '0;
      valid_q <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      dcnt_q  <= dcnt_d;
      valid_q <= valid_d;
      empty_q <= empty_d;
    end
  end

  // read-return delay line matched to the RAM latency
  always_ff @(posedge nnclk) begin
    if (nnreset) begin
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= rd_en;
      idx_pipe_q[0] <= k_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        idx_pipe_q[i] <= idx_pipe_q[i-1];
      end
    end
  end

  nn_max_cmp u_cmp (
    .clk      (nnclk),
    .rst      (nnreset),
    .clr      (clr),
    .in_valid (vld_pipe_q[RD_LAT-1]),
    .in_val   (bus.output_dout),
    .in_idx   (idx_pipe_q[RD_LAT-1]),
    .max_val  (bus.class_val),
    .max_idx  (bus.class_idx)
  );

  assign bus.output_addr = addr_q;
  assign bus.output_en   = rd_en;
  assign bus.output_we   = 4'b0000;
  assign bus.busy        = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.done        = (state_q == FIN);
  assign bus.valid       = valid_q;
  assign bus.empty       = empty_q;
endmodule

// File: tb/tb_nn_argmax.sv
// Bench for nn_argmax: fixed vector table, corner sequences and randomized runs vs. a max/first-index model.
module tb_nn_argmax;
  import nn_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        en;
    logic [3:0]  we;
    logic        busy, done, valid, empty;
    logic [4:0]  idx;
    logic [31:0] val;
  } outs_t;

  typedef struct {
    int          pat;
    int          n;
    logic [4:0]  eidx;
    logic [31:0] eval;
    logic        eemp;
    int          elat;
  } vec_t;

  logic nnclk, nnreset;
  nn_argmax_if busA ();
  nn_argmax_if busB ();

  nn_argmax #(.BASE_ADDR(32'h0), .ADDR_STRIDE(4), .RD_LAT(1)) u_a (
    .nnclk(nnclk), .nnreset(nnreset), .bus(busA));
  nn_argmax #(.BASE_ADDR(32'h0), .ADDR_STRIDE(4), .RD_LAT(2)) u_b (
    .nnclk(nnclk), .nnreset(nnreset), .bus(busB));

  initial nnclk = 1'b0;
  always #5 nnclk = ~nnclk;

  int checks = 0;
  int failures = 0;

  // shared RAM contents; A sees 1-cycle reads, B sees 2-cycle reads
  logic [31:0] mem [32];
  logic [31:0] ra1, rb1, rb2;
  always @(posedge nnclk) begin
    ra1 <= busA.output_en ? mem[busA.output_addr[6:2]] : 32'h0;
    rb1 <= busB.output_en ? mem[busB.output_addr[6:2]] : 32'h0;
    rb2 <= rb1;
  end
  assign busA.output_dout = ra1;
  assign busB.output_dout = rb2;

  // issued-address log with cycle stamps
  int cyc = 0;
  logic [31:0] qa[$], qb[$];
  int qca[$], qcb[$];
  always @(posedge nnclk) begin
    cyc <= cyc + 1;
    if (busA.output_en) begin qa.push_back(busA.output_addr); qca.push_back(cyc); end
    if (busB.output_en) begin qb.push_back(busB.output_addr); qcb.push_back(cyc); end
  end

  outs_t oA, oB;
  always_comb begin
    oA.addr = busA.output_addr; oA.en = busA.output_en; oA.we = busA.output_we;
    oA.busy = busA.busy; oA.done = busA.done; oA.valid = busA.valid; oA.empty = busA.empty;
    oA.idx = busA.class_idx; oA.val = busA.class_val;
    oB.addr = busB.output_addr; oB.en = busB.output_en; oB.we = busB.output_we;
    oB.busy = busB.busy; oB.done = busB.done; oB.valid = busB.valid; oB.empty = busB.empty;
    oB.idx = busB.class_idx; oB.val = busB.class_val;
  end

  function automatic outs_t get(int sel);
    return (sel == 0) ? oA : oB;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [4:0] n);
    if (sel == 0) begin busA.start = s; busA.num_of_output = n; end
    else          begin busB.start = s; busB.num_of_output = n; end
  endtask

  task automatic chk_reset_outs(input int sel, input string tag);
    outs_t o;
    o = get(sel);
    chk({tag, "_addr"}, 64'(o.addr), 64'h0);
    chk({tag, "_ctl"}, 64'({o.en, o.we, o.busy, o.done, o.valid, o.empty, o.idx}), 64'h0);
    chk({tag, "_val"}, 64'(o.val), 64'h0);
  endtask

  // reference: largest signed value, then the first index holding it
  function automatic void model(input int n, output logic [4:0] idx, output logic [31:0] val);
    int mx;
    idx = 5'd0;
    val = NEG_MAX;
    if (n > 0) begin
      mx = int'(mem[0]);
      for (int k = 1; k < n; k++) if (int'(mem[k]) > mx) mx = int'(mem[k]);
      val = 32'(mx);
      for (int k = n - 1; k >= 0; k--) if (int'(mem[k]) == mx) idx = 5'(k);
    end
  endfunction

  task automatic fill(input int pat);
    for (int k = 0; k < 32; k++) begin
      case (pat)
        0: mem[k] = 32'(k - 15);
        1: mem[k] = (k == 7) ? 32'hFFFF_FFFF : 32'(-1000);
        2: mem[k] = (k == 3 || k == 20) ? 32'd500 : 32'd0;
        4: mem[k] = (k == 0) ? NEG_MAX : 32'h7FFF_FFFF;
        default: mem[k] = $urandom;
      endcase
    end
  endtask

  // one classification: start, optional stray start pulse, wait for done (bounded)
  task automatic run(input int sel, input logic [4:0] n, input int pulse_at,
                     output int lat, output outs_t fin, output outs_t first,
                     output bit addr_ok, output bit done_once);
    outs_t o;
    logic [31:0] q[$];
    int qc[$];
    @(negedge nnclk);
    if (sel == 0) begin qa.delete(); qca.delete(); end
    else          begin qb.delete(); qcb.delete(); end
    drive(sel, 1'b1, n);
    @(posedge nnclk); #1;
    drive(sel, 1'b0, n);
    o = get(sel);
    first = o;
    lat = 1;
    while (!o.done && lat < 200) begin
      @(posedge nnclk); #1;
      lat++;
      if (lat == pulse_at) drive(sel, 1'b1, 5'd3);
      else                 drive(sel, 1'b0, n);
      o = get(sel);
    end
    if (!o.done) chk("done_timeout", 64'(lat), 64'(0));
    fin = o;
    @(posedge nnclk); #1;
    o = get(sel);
    done_once = !o.done;
    if (sel == 0) begin q = qa; qc = qca; end
    else          begin q = qb; qc = qcb; end
    addr_ok = (q.size() == int'(n));
    for (int k = 0; k < q.size(); k++)
      if (q[k] !== 32'(4 * k) || qc[k] != qc[0] + k) addr_ok = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    int lat;
    outs_t fin, first;
    bit aok, d1, seen;
    logic [4:0] eidx;
    logic [31:0] ev;
    int n;

    tbl[0] = '{pat: 0, n: 30, eidx: 5'd29, eval: 32'd14,        eemp: 1'b0, elat: 32};
    tbl[1] = '{pat: 1, n: 30, eidx: 5'd7,  eval: 32'hFFFF_FFFF, eemp: 1'b0, elat: 32};
    tbl[2] = '{pat: 2, n: 30, eidx: 5'd3,  eval: 32'd500,       eemp: 1'b0, elat: 32};
    tbl[3] = '{pat: 3, n: 0,  eidx: 5'd0,  eval: NEG_MAX,       eemp: 1'b1, elat: 1};
    tbl[4] = '{pat: 4, n: 1,  eidx: 5'd0,  eval: NEG_MAX,       eemp: 1'b0, elat: 3};

    nnreset = 1'b1;
    drive(0, 1'b0, 5'd0);
    drive(1, 1'b0, 5'd0);
    fill(0);
    repeat (3) @(posedge nnclk);
    #1;
    chk_reset_outs(0, "rstA");
    chk_reset_outs(1, "rstB");
    nnreset = 1'b0;

    foreach (tbl[i]) begin
      fill(tbl[i].pat);
      run(0, 5'(tbl[i].n), 0, lat, fin, first, aok, d1);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(tbl[i].elat));
      chk($sformatf("v%0d_idx", i), 64'(fin.idx), 64'(tbl[i].eidx));
      chk($sformatf("v%0d_val", i), 64'(fin.val), 64'(tbl[i].eval));
      chk($sformatf("v%0d_flags", i), 64'({fin.valid, fin.empty, fin.busy}), 64'({1'b1, tbl[i].eemp, 1'b0}));
      chk($sformatf("v%0d_addr", i), 64'(aok), 64'(1));
      chk($sformatf("v%0d_pulse", i), 64'(d1), 64'(1));
      chk($sformatf("v%0d_we", i), 64'(fin.we), 64'h0);
      if (tbl[i].n > 0)
        chk($sformatf("v%0d_first", i), 64'({first.busy, first.valid, first.empty}), 64'({1'b1, 1'b0, 1'b0}));
    end

    // stray start during the scan must be ignored
    fill(0);
    run(0, 5'd30, 6, lat, fin, first, aok, d1);
    chk("repulse_lat", 64'(lat), 64'(32));
    chk("repulse_res", 64'({fin.idx, fin.val}), 64'({5'd29, 32'd14}));
    chk("repulse_addr", 64'(aok), 64'(1));

    // reset in cycle 10 of a scan: aborts without done, then a clean rerun
    @(negedge nnclk);
    drive(0, 1'b1, 5'd30);
    @(posedge nnclk); #1;
    drive(0, 1'b0, 5'd30);
    seen = 1'b0;
    repeat (9) begin @(posedge nnclk); #1; if (busA.done) seen = 1'b1; end
    nnreset = 1'b1;
    @(posedge nnclk); #1;
    nnreset = 1'b0;
    chk_reset_outs(0, "midrst");
    repeat (40) begin @(posedge nnclk); #1; if (busA.done) seen = 1'b1; end
    chk("midrst_nodone", 64'(seen), 64'(0));
    run(0, 5'd30, 0, lat, fin, first, aok, d1);
    chk("postrst_lat", 64'(lat), 64'(32));
    chk("postrst_res", 64'({fin.idx, fin.val}), 64'({5'd29, 32'd14}));

    // 2-cycle RAM latency instance
    run(1, 5'd30, 0, lat, fin, first, aok, d1);
    chk("lat2_lat", 64'(lat), 64'(33));
    chk("lat2_res", 64'({fin.idx, fin.val}), 64'({5'd29, 32'd14}));
    chk("lat2_addr", 64'(aok), 64'(1));

    // randomized runs with a mix of wide values and small clustered ones (forces ties)
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 31);
      for (int k = 0; k < 32; k++)
        mem[k] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7) - 4);
      model(n, eidx, ev);
      run(0, 5'(n), 0, lat, fin, first, aok, d1);
      chk($sformatf("rnd%0d_n%0d_lat", r, n), 64'(lat), 64'((n == 0) ? 1 : n + 2));
      chk($sformatf("rnd%0d_idx", r), 64'(fin.idx), 64'(eidx));
      chk($sformatf("rnd%0d_val", r), 64'(fin.val), 64'(ev));
      chk($sformatf("rnd%0d_empty", r), 64'(fin.empty), 64'(n == 0));
      chk($sformatf("rnd%0d_addr", r), 64'(aok), 64'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
